// File: rtl/bus_capture_pkg.sv
// Shared constants, state encoding and nibble selection for the bus capture block.
package bus_capture_pkg;

  localparam int LED_W         = 5;
  localparam int PAGES         = 4;
  localparam int DEFAULT_DEPTH = 4;
  localparam int WORD_W        = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  function automatic logic [3:0] nibble_sel(input logic [WORD_W-1:0] word, input logic [1:0] page);
    logic [3:0] nib;
    case (page)
      2'd0:    nib = word[3:0];
      2'd1:    nib = word[7:4];
      2'd2:    nib = word[11:8];
      2'd3:    nib = word[15:12];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/bus_capture_fifo.sv
// Synchronous FIFO of captured words; push is accepted when full if a pop happens
// in the same edge. Exposes the head and the word behind it for look-ahead display.
module bus_capture_fifo
  import bus_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wr_data,
  output logic [WORD_W-1:0] head,
  output logic [WORD_W-1:0] head_next,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     rd_ptr_inc_s;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic              full_r;
  logic              empty_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign do_pop_s     = pop && !empty_r;
  assign do_push_s    = push && (!full_r || do_pop_s);
  assign rd_ptr_inc_s = rd_ptr_r + AW'(1);

  // Occupancy after this edge
  always_comb begin
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and occupancy flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_inc_s;
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == CW'(0));
    end
  end

  // Word storage; contents survive reset
  always_ff @(posedge clk) begin
    if (reset && do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign head      = mem_r[rd_ptr_r];
  assign head_next = mem_r[rd_ptr_inc_s];
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;

endmodule

// File: rtl/bus_capture.sv
// Captures bus words into a FIFO and pages the oldest word out on the LEDs, one
// nibble per step. LED drive is computed one edge ahead so it leaves a register.
module bus_capture
  import bus_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] DATA,
  input  logic              capture,
  input  logic              step,
  output logic [LED_W-1:0]  leds,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  state_t            state_r;
  state_t            state_next_s;
  logic [1:0]        page_r;
  logic [1:0]        page_next_s;
  logic [LED_W-1:0]  leds_r;
  logic [LED_W-1:0]  leds_next_s;
  logic              overflow_r;
  logic              overflow_next_s;
  logic              pop_s;
  logic [WORD_W-1:0] new_head_s;
  logic [WORD_W-1:0] head_s;
  logic [WORD_W-1:0] head_next_s;
  logic [CW-1:0]     count_s;
  logic              full_s;
  logic              empty_s;

  assign pop_s = (state_r == SHOW) && step && (page_r == 2'd3);

  bus_capture_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .pop       (pop_s),
    .wr_data   (DATA),
    .head      (head_s),
    .head_next (head_next_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Display FSM next state; new_head_s is the FIFO head as it will be after this edge
  always_comb begin
    state_next_s    = state_r;
    page_next_s     = page_r;
    new_head_s      = head_s;
    overflow_next_s = overflow_r | (capture & full_s & ~pop_s);
    case (state_r)
      IDLE: begin
        if (capture) begin
          state_next_s = SHOW;
          page_next_s  = 2'd0;
          new_head_s   = DATA;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHOW: begin
        if (step && (page_r == 2'd3)) begin
          page_next_s = 2'd0;
          if (count_s == CW'(1)) begin
            if (capture) begin
              new_head_s = DATA;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            new_head_s = head_next_s;
          end
        end else if (step) begin
          page_next_s = page_r + 2'd1;
        end else begin
          page_next_s = page_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        page_next_s  = 2'd0;
      end
    endcase
    if (state_next_s == SHOW) begin
      leds_next_s = {(page_next_s == 2'd0), nibble_sel(new_head_s, page_next_s)};
    end else begin
      leds_next_s = {LED_W{1'b0}};
    end
  end

  // Display state, LED drive and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      page_r     <= 2'd0;
      leds_r     <= {LED_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      page_r     <= page_next_s;
      leds_r     <= leds_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  assign leds     = leds_r;
  assign overflow = overflow_r;
  assign empty    = empty_s;
  assign full     = full_s;
  assign count    = count_s;

endmodule

// File: doc/bus_capture.md
BUS_CAPTURE -- requirements
Module: bus_capture

Interface
REQ-001 Parameter DEPTH, default 4, number of captured 16-bit words buffered; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state changes on rising edge (the one-shot pulsed clock in the top level).
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 DATA  input  16  shared system bus value (read only, never driven by this block).
REQ-005 capture  input  1  when high at a clk edge, sample DATA into buffer.
REQ-006 step  input  1  when high at a clk edge, advance the LED display by one page.
REQ-007 leds  output  5  leds[3:0] = displayed nibble, leds[4] = first-page marker.
REQ-008 empty  output  1  buffer holds no words.
REQ-009 full  output  1  buffer holds DEPTH words.
REQ-010 count  output  clog2(DEPTH+1)  number of words held.
REQ-011 overflow  output  1  sticky; a capture was dropped.

Function
REQ-012 Buffer SHALL be FIFO ordered; head word = oldest captured word.
REQ-013 States: IDLE (empty), SHOW (non-empty, page index p in 0..3).
REQ-014 IDLE: leds = 5'b00000; step ignored.
REQ-015 SHOW: leds[3:0] = head[4p+3:4p]; leds[4] = 1 when p==0, else 0.
REQ-016 Outputs SHALL be derived from registered state only; no combinational path from DATA, capture or step to any output.
REQ-017 Capture while not full: word written at the edge; count+1 visible after that edge.
REQ-018 Capture into empty buffer: after the same edge, state = SHOW, p = 0, leds show DATA[3:0] with leds[4]=1 (one-edge latency).
REQ-019 Step in SHOW with p<3: p <= p+1.
REQ-020 Step in SHOW with p==3: pop head, p <= 0; if buffer becomes empty, state <= IDLE.
REQ-021 Capture while full with no simultaneous pop: word dropped, count unchanged, overflow <= 1.
REQ-022 Capture and popping step in same edge (including when full): both take effect; count unchanged; no overflow.
REQ-023 Capture and popping step on a one-word buffer: new word becomes head, p = 0, state stays SHOW.
REQ-024 Non-popping step with capture: p advances, new word appended.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 overflow SHALL clear only on reset.

Reset
REQ-027 reset low at an edge: count=0, pointers=0, p=0, state=IDLE, overflow=0, leds=0, empty=1, full=0; capture and step ignored that edge.
REQ-028 Reset mid-display or while full SHALL discard all buffered words.
REQ-029 Buffer storage contents need not be cleared.

Structure
REQ-030 Shared package SHALL hold: LED width (5), nibble pages per word (4), default DEPTH, state encoding IDLE/SHOW.
REQ-031 One sub-module bus_capture_fifo (synchronous FIFO, push/pop/count/full/empty, simultaneous push+pop when full allowed); display FSM and overflow flag in bus_capture.

Verification
REQ-032 Reset low one edge, then capture DATA=16'hA5C3 -> leds=5'b10011, count=1, empty=0.
REQ-033 Then four steps -> leds 5'b01100, 5'b00101, 5'b01010, then 5'b00000 with empty=1, state IDLE.
REQ-034 DEPTH=4: capture 1111,2222,3333,4444,5555 (hex) -> full=1, count=4, overflow=1; pop all -> nibble-0 display order 1,2,3,4.
REQ-035 Full buffer, capture 16'h9999 with step at p==3 -> count stays 4, overflow stays 0, last popped word shown is 9999 after draining.
REQ-036 One word 16'h00F0 at p==3, capture 16'hBEEF with step -> leds=5'b11111, count=1, state SHOW.
REQ-037 Three words held, p=2, reset low -> count=0, leds=0, overflow=0; step next edge -> leds stay 0.
